// File: rtl/usg_ctrl_pkg.sv
// ============================================================================
// Module   : usg_ctrl_pkg
// Purpose  : Shared control-packet encodings for the USG lookup stages.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package usg_ctrl_pkg;

  typedef logic [7:0] lmid_t;

  // Beat-type bits and header field positions
  localparam int HEAD_BIT = 132;
  localparam int TAIL_BIT = 133;
  localparam int OPC_LSB  = 124;
  localparam int LMID_LSB = 96;
  localparam int IDX_LSB  = 72;
  localparam int CLS_LSB  = 64;
  localparam int DATA_LSB = 16;
  localparam int VLD_BIT  = 15;

  localparam logic [2:0] CLS_PATHTB = 3'd4;

  localparam logic [2:0] OP_READ     = 3'b001;
  localparam logic [2:0] OP_WRITE    = 3'b010;
  localparam logic [2:0] OP_INVAL    = 3'b011;
  localparam logic [2:0] OP_SET_DEF  = 3'b100;
  localparam logic [2:0] OP_READ_CLR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_DEC   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4,
    ST_FWD   = 3'd5,
    ST_DRAIN = 3'd6
  } ctrl_state_e;

  function automatic logic hdr_match(input logic [133:0] beat, input lmid_t id);
    return (beat[LMID_LSB +: 8] == id) && (beat[CLS_LSB +: 3] == CLS_PATHTB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Purpose  : Single-clock show-ahead FIFO; writes while full are dropped.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_sync #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic [D:0]   count
);

  logic [W-1:0] mem [2**D];
  logic [D:0]   wptr;
  logic [D:0]   rptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr && !full) wptr <= wptr + 1'b1;
      if (rd && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr && !full) mem[wptr[D-1:0]] <= wdata;
  end

  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = count[D];
  assign rdata = mem[rptr[D-1:0]];

endmodule

`default_nettype wire

// File: rtl/lookup_pathid_mc.sv
// ============================================================================
// Module   : lookup_pathid_mc
// Purpose  : Multi-channel ruleID -> pathID lookup with control-packet config.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lookup_pathid_mc
  import usg_ctrl_pkg::*;
#(
  parameter int LMID     = 7,
  parameter int W_PKT    = 134,
  parameter int W_RULEID = 16,
  parameter int W_PATH   = 16,
  parameter int D_PATHTB = 6,
  parameter int N_CH     = 2,
  parameter int W_CNT    = 32,
  parameter int D_FIFO   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ruleID_valid,
  input  logic [N_CH*W_RULEID-1:0] ruleID,
  input  logic [N_CH-1:0]          hit,
  output logic [N_CH-1:0]          pathID_valid,
  output logic [N_CH*W_PATH-1:0]   pathID,
  output logic [N_CH-1:0]          pathID_miss,
  input  logic                     cin_data_wr,
  input  logic [W_PKT-1:0]         cin_data,
  output logic                     cin_ready,
  output logic                     cout_data_wr,
  output logic [W_PKT-1:0]         cout_data,
  input  logic                     cout_ready
);

  localparam int N_ENT = 2**D_PATHTB;
  localparam logic [D_FIFO:0] FIFO_HIWAT = (D_FIFO+1)'(2**D_FIFO - 8);

  logic [W_PATH-1:0]   tbl [N_ENT];
  logic [W_CNT-1:0]    cnt [N_ENT];
  logic [N_ENT-1:0]    ent_valid;
  logic [W_PATH-1:0]   def_path;

  logic [N_CH-1:0]     s1_valid;
  logic [N_CH-1:0]     s1_hit;
  logic [D_PATHTB-1:0] s1_idx [N_CH];
  logic [N_CH-1:0]     s1_res_hit;
  logic [2:0]          inc [N_ENT];

  ctrl_state_e         state, state_nxt;
  logic [W_PKT-1:0]    beat_r, beat_nxt;
  logic                fifo_rd, fifo_empty, fifo_full_unused;
  logic [W_PKT-1:0]    fifo_rdata;
  logic [D_FIFO:0]     fifo_count;
  logic                tbl_we, ent_inv, def_we, cnt_clr;
  logic [D_PATHTB-1:0] cmd_idx;
  logic [W_PATH-1:0]   cmd_data;
  logic [N_CH-1:0]     unused_rid;

  function automatic logic [W_CNT-1:0] sat_add(input logic [W_CNT-1:0] a, input logic [2:0] b);
    logic [W_CNT:0] s;
    s = {1'b0, a} + {{(W_CNT-2){1'b0}}, b};
    return s[W_CNT] ? '1 : s[W_CNT-1:0];
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_unused
    assign unused_rid[c] = ^ruleID[c*W_RULEID+D_PATHTB +: W_RULEID-D_PATHTB];
  end

  // Lookup pipeline: stage 1 registers the request, stage 2 the table result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= '0;
      s1_hit       <= '0;
      pathID_valid <= '0;
      pathID       <= '0;
      pathID_miss  <= '0;
      for (int c = 0; c < N_CH; c++) s1_idx[c] <= '0;
    end else begin
      s1_valid     <= ruleID_valid;
      s1_hit       <= hit;
      pathID_valid <= s1_valid;
      for (int c = 0; c < N_CH; c++) begin
        s1_idx[c] <= ruleID[c*W_RULEID +: D_PATHTB];
        if (s1_valid[c]) begin
          pathID[c*W_PATH +: W_PATH] <= s1_res_hit[c] ? tbl[s1_idx[c]] : def_path;
          pathID_miss[c]             <= ~s1_res_hit[c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++)
      s1_res_hit[c] = s1_valid[c] & s1_hit[c] & ent_valid[s1_idx[c]];
    for (int e = 0; e < N_ENT; e++) begin
      inc[e] = 3'd0;
      for (int c = 0; c < N_CH; c++)
        if (s1_res_hit[c] && (s1_idx[c] == D_PATHTB'(e))) inc[e] = inc[e] + 3'd1;
    end
  end

  // Table writes land at the end of EXEC, so a same-cycle stage-1 read sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      def_path  <= '0;
      for (int e = 0; e < N_ENT; e++) begin
        tbl[e] <= '0;
        cnt[e] <= '0;
      end
    end else begin
      if (tbl_we) begin
        tbl[cmd_idx]       <= cmd_data;
        ent_valid[cmd_idx] <= 1'b1;
      end
      if (ent_inv) ent_valid[cmd_idx] <= 1'b0;
      if (def_we)  def_path <= cmd_data;
      for (int e = 0; e < N_ENT; e++) begin
        if (cnt_clr && (cmd_idx == D_PATHTB'(e))) cnt[e] <= W_CNT'(inc[e]);
        else                                     cnt[e] <= sat_add(cnt[e], inc[e]);
      end
    end
  end

  fifo_sync #(.W(W_PKT), .D(D_FIFO)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (cin_data_wr),
    .wdata (cin_data),
    .rd    (fifo_rd),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (fifo_count)
  );

  assign cin_ready = (fifo_count < FIFO_HIWAT);
  assign cmd_idx   = beat_r[IDX_LSB +: D_PATHTB];
  assign cmd_data  = beat_r[DATA_LSB +: W_PATH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      beat_r <= '0;
    end else begin
      state  <= state_nxt;
      beat_r <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_r;
    fifo_rd      = 1'b0;
    cout_data_wr = 1'b0;
    cout_data    = beat_r;
    tbl_we       = 1'b0;
    ent_inv      = 1'b0;
    def_we       = 1'b0;
    cnt_clr      = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_POP;
      ST_POP: begin
        fifo_rd   = 1'b1;
        beat_nxt  = fifo_rdata;
        state_nxt = ST_DEC;
      end
      ST_DEC: state_nxt = hdr_match(beat_r, lmid_t'(LMID)) ? ST_EXEC : ST_FWD;
      ST_EXEC: begin
        case (beat_r[OPC_LSB +: 3])
          OP_READ: begin
            beat_nxt[DATA_LSB +: W_PATH] = tbl[cmd_idx];
            beat_nxt[VLD_BIT]            = ent_valid[cmd_idx];
            beat_nxt[VLD_BIT-1:0]        = '0;
          end
          OP_WRITE:   tbl_we  = 1'b1;
          OP_INVAL:   ent_inv = 1'b1;
          OP_SET_DEF: def_we  = 1'b1;
          OP_READ_CLR: begin
            cnt_clr        = 1'b1;
            beat_nxt[31:0] = 32'(cnt[cmd_idx]);
          end
          default: ;
        endcase
        state_nxt = ST_RESP;
      end
      ST_RESP, ST_FWD: begin
        if (cout_ready) begin
          cout_data_wr = 1'b1;
          state_nxt    = beat_r[TAIL_BIT] ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cout_data = fifo_rdata;
        if (!fifo_empty && cout_ready) begin
          cout_data_wr = 1'b1;
          fifo_rd      = 1'b1;
          if (fifo_rdata[TAIL_BIT]) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
